keypad_scanner: RTL

- Upstream stage of the lock decider. Scans a 4x3 matrix keypad (digits 0-9, '*', '#'), debounces key presses and releases, and outputs a 4-bit key code.
- Outputs: a one-clock Valid_1 pulse per press, and an S_Row level that stays high while a key is held.
- Code map: 0-9 = 4'b0000-4'b1001, '#' = 4'b1010, '*' = 4'b1011.

---
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// ---------------------------------------------------------------------------
// Scans a 4x3 active-low matrix keypad. Rows are driven one at a time, and the
// column lines are read back on every scan tick. A key is accepted after
// DEBOUNCE_CNT stable ticks. It is released after DEBOUNCE_CNT stable high
// ticks. Each accepted press gives one Valid_1 pulse and a 4-bit code.
//
// Ports
//   clk      in   1  system clock
//   reset_1  in   1  asynchronous active-low reset
//   Col      in   3  column lines, active-low, Col[0] = left column
//   Row      out  4  row drive, active-low, exactly one bit low
//   Code_1   out  4  code of last accepted key (0-9, '#'=1010, '*'=1011)
//   Valid_1  out  1  one-clock pulse per accepted press
//   S_Row    out  1  debounced key-held level
//
// Handshake: Valid_1 is a single-cycle strobe and there is no ready. Code_1 is
// stable from the Valid_1 cycle until the next accepted press.
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset_1,
    input  logic [2:0] Col,
    output logic [3:0] Row,
    output logic [3:0] Code_1,
    output logic       Valid_1,
    output logic       S_Row
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Wide enough to hold DEBOUNCE_CNT itself.
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [2:0]        col_meta_q, col_sync_q;
    logic [1:0]        row_q, row_d;
    logic [1:0]        lat_col_q, lat_col_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              s_row_q, s_row_d;

    logic              tick;
    logic              any_low;
    logic [1:0]        sel_col;
    logic              lat_low;

    // Maps a row and column to the key code. Row 3 holds '*', '0' and '#'.
    // Rows 0-2 hold the digits 1-9, numbered as row*3 + col + 1.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'd0;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = 4'b1011;
                2'd1:    code = 4'b0000;
                default: code = 4'b1010;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign any_low = ~&col_sync_q;

    // When several columns are low, the lowest index wins.
    always_comb begin
        sel_col = 2'd2;
        if (!col_sync_q[0])      sel_col = 2'd0;
        else if (!col_sync_q[1]) sel_col = 2'd1;
    end

    always_comb begin
        lat_low = 1'b0;
        case (lat_col_q)
            2'd0:    lat_low = ~col_sync_q[0];
            2'd1:    lat_low = ~col_sync_q[1];
            default: lat_low = ~col_sync_q[2];
        endcase
    end

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            tick_cnt_q <= '0;
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
            state_q    <= ST_SCAN;
            row_q      <= 2'd0;
            lat_col_q  <= 2'd0;
            deb_q      <= '0;
            code_q     <= 4'b0000;
            valid_q    <= 1'b0;
            s_row_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            col_meta_q <= Col;
            col_sync_q <= col_meta_q;
            state_q    <= state_d;
            row_q      <= row_d;
            lat_col_q  <= lat_col_d;
            deb_q      <= deb_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            s_row_q    <= s_row_d;
        end
    end

    // Accepting a key sets the code, the strobe and the held level on the
    // same edge, so Valid_1 comes one clock after the final debounce tick.
    // deb_q doubles as the release counter while a key is held.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        lat_col_d = lat_col_q;
        deb_d     = deb_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        s_row_d   = s_row_q;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        lat_col_d = sel_col;
                        if (DEB_ONE == DEB_MAX) begin
                            state_d = ST_PRESSED;
                            deb_d   = '0;
                            code_d  = key_code(row_q, sel_col);
                            valid_d = 1'b1;
                            s_row_d = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            deb_d   = DEB_ONE;
                        end
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (lat_low) begin
                        if ((deb_q + DEB_ONE) == DEB_MAX) begin
                            state_d = ST_PRESSED;
                            deb_d   = '0;
                            code_d  = key_code(row_q, lat_col_q);
                            valid_d = 1'b1;
                            s_row_d = 1'b1;
                        end else begin
                            deb_d = deb_q + DEB_ONE;
                        end
                    end else begin
                        // Bounce or early release: the press is dropped.
                        state_d = ST_SCAN;
                        deb_d   = '0;
                        row_d   = row_q + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (lat_low) begin
                        deb_d = '0;
                    end else if ((deb_q + DEB_ONE) == DEB_MAX) begin
                        state_d = ST_SCAN;
                        deb_d   = '0;
                        s_row_d = 1'b0;
                        row_d   = row_q + 2'd1;
                    end else begin
                        deb_d = deb_q + DEB_ONE;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    deb_d   = '0;
                end
            endcase
        end
    end

    assign Row     = ~(4'b0001 << row_q);
    assign Code_1  = code_q;
    assign Valid_1 = valid_q;
    assign S_Row   = s_row_q;

endmodule
